// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefWidth  = 8;
    localparam int unsigned DefNumReq = 4;

    // Width of a requester index; at least one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Request/response bundle between requesters and the shared multiplier.
interface mult_rr_scheduler_if
    import mult_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned WIDTH   = DefWidth
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [2*WIDTH-1:0]       resp_product;
    logic [IdW-1:0]           resp_id;
    logic                     busy;

    // Requesters and the response consumer.
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_product, resp_id, busy
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_product, resp_id, busy
    );

endinterface

// File: rtl/rp_mult_iter.sv
// Iterative shift-and-add multiplier datapath: one step per cycle while step_i is high.
module rp_mult_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               zero_o
);

    logic [2*WIDTH-1:0] a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;

    // Load operands on accept, otherwise add-if-odd and shift on each step.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (load_i) begin
            a_d   = {{WIDTH{1'b0}}, a_i};
            b_d   = b_i;
            acc_d = '0;
        end else if (step_i) begin
            if (b_q[0]) begin
                acc_d = acc_q + a_q;
            end
            a_d = a_q << 1;
            b_d = b_q >> 1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    // Multiplier will be exhausted after the step taken on this edge.
    assign zero_o    = ((b_q >> 1) == '0);
    assign product_o = acc_q;

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin arbiter + FSM sharing one iterative multiplier among NUM_REQ requesters.
module mult_rr_scheduler
    import mult_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned WIDTH   = DefWidth
) (
    input logic                clk,
    input logic                rst_n,
    mult_rr_scheduler_if.slave bus
);

    localparam int unsigned    IdW      = id_width(NUM_REQ);
    localparam logic [IdW-1:0] LastInit = IdW'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [IdW-1:0]     last_grant_q, id_q, grant_idx;
    logic               grant_vld, accept, load, step, iter_zero;
    logic [NUM_REQ-1:0] grant_oh;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [2*WIDTH-1:0] product;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            if (!grant_vld && bus.req_valid[(32'(last_grant_q) + off) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = IdW'((32'(last_grant_q) + off) % NUM_REQ);
            end
        end
    end

    // One-hot form of the winner plus its operands.
    always_comb begin
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
        sel_a = bus.req_a[grant_idx*WIDTH +: WIDTH];
        sel_b = bus.req_b[grant_idx*WIDTH +: WIDTH];
    end

    assign accept = (state_q == StIdle) && grant_vld;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; b==0 skips straight to the response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (sel_b == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (iter_zero) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; grant is masked while reset is asserted.
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = 1'b0;
        bus.busy       = 1'b0;
        load           = 1'b0;
        step           = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.req_ready = rst_n ? grant_oh : '0;
                load          = accept;
            end
            StRun: begin
                bus.busy = 1'b1;
                step     = 1'b1;
            end
            StDone: begin
                bus.busy       = 1'b1;
                bus.resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Round-robin pointer and response ID, captured on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= LastInit;
            id_q         <= '0;
        end else if (accept) begin
            last_grant_q <= grant_idx;
            id_q         <= grant_idx;
        end
    end

    rp_mult_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .a_i      (sel_a),
        .b_i      (sel_b),
        .product_o(product),
        .zero_o   (iter_zero)
    );

    assign bus.resp_product = product;
    assign bus.resp_id      = id_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed self-checking bench for mult_rr_scheduler.
module tb_mult_rr_scheduler;

    localparam int unsigned NumReq = 4;
    localparam int unsigned Width  = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mult_rr_scheduler_if #(.NUM_REQ(NumReq), .WIDTH(Width)) bus ();

    mult_rr_scheduler #(
        .NUM_REQ(NumReq),
        .WIDTH  (Width)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*Width +: Width] = a;
        bus.req_b[i*Width +: Width] = b;
        bus.req_valid[i]            = 1'b1;
    endtask

    // Entered just after the accept edge; counts edges until resp_valid.
    task automatic wait_resp(input string tag, input int exp_k, input int exp_p, input int exp_id);
        int edges = 0;
        while (!bus.resp_valid && edges < 20) begin
            step_clk();
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(exp_k));
        check({tag, " product"}, 32'(bus.resp_product), 32'(exp_p));
        check({tag, " id"}, 32'(bus.resp_id), 32'(exp_id));
    endtask

    task automatic take_resp(input string tag);
        bus.resp_ready = 1'b1;
        step_clk();
        bus.resp_ready = 1'b0;
        check({tag, " busy after resp"}, 32'(bus.busy), 0);
    endtask

    task automatic run_op(input string tag, input int i, input logic [7:0] a,
                          input logic [7:0] b, input int exp_k, input int exp_p);
        set_req(i, a, b);
        #1;
        check({tag, " grant"}, 32'(bus.req_ready), 32'(1 << i));
        step_clk();
        bus.req_valid[i] = 1'b0;
        wait_resp(tag, exp_k, exp_p, i);
        take_resp(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step_clk();
        step_clk();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        set_req(0, 8'd6, 8'd7);
        #1;
        // Reset state, with a request pending.
        check("rst req_ready", 32'(bus.req_ready), 0);
        check("rst resp_valid", 32'(bus.resp_valid), 0);
        check("rst product", 32'(bus.resp_product), 0);
        check("rst id", 32'(bus.resp_id), 0);
        check("rst busy", 32'(bus.busy), 0);
        step_clk();
        step_clk();
        bus.req_valid = '0;
        rst_n         = 1'b1;

        // Single requester.
        run_op("t1 6x7", 0, 8'd6, 8'd7, 3, 42);

        // Simultaneous requests and fairness.
        apply_reset();
        set_req(0, 8'd15, 8'd5);
        set_req(2, 8'd8, 8'd3);
        #1;
        check("t2 grant r0", 32'(bus.req_ready), 32'h1);
        step_clk();
        bus.req_valid[0] = 1'b0;
        check("t2 no grant in run", 32'(bus.req_ready), 0);
        check("t2 busy in run", 32'(bus.busy), 1);
        wait_resp("t2 r0", 3, 75, 0);
        take_resp("t2 r0");
        #1;
        check("t2 grant r2", 32'(bus.req_ready), 32'h4);
        step_clk();
        bus.req_valid[2] = 1'b0;
        set_req(1, 8'd10, 8'd2);
        set_req(2, 8'd4, 8'd4);
        wait_resp("t2 r2", 2, 24, 2);
        take_resp("t2 r2");
        #1;
        check("t2 grant r1 before r2", 32'(bus.req_ready), 32'h2);
        step_clk();
        bus.req_valid[1] = 1'b0;
        wait_resp("t2 r1", 2, 20, 1);
        take_resp("t2 r1");
        #1;
        check("t2 grant r2 again", 32'(bus.req_ready), 32'h4);
        step_clk();
        bus.req_valid[2] = 1'b0;
        wait_resp("t2 r2b", 3, 16, 2);
        take_resp("t2 r2b");

        // Zero multiplier and full-width operands.
        run_op("t3 9x0", 1, 8'd9, 8'd0, 0, 0);
        run_op("t4 255x255", 3, 8'd255, 8'd255, 8, 65025);
        run_op("t4 1x128", 0, 8'd1, 8'd128, 8, 128);

        // Back-pressure in DONE with another request pending.
        set_req(3, 8'd13, 8'd11);
        #1;
        check("t5 grant r3", 32'(bus.req_ready), 32'h8);
        step_clk();
        bus.req_valid[3] = 1'b0;
        set_req(1, 8'd7, 8'd7);
        wait_resp("t5 r3", 4, 143, 3);
        for (int c = 0; c < 10; c++) begin
            step_clk();
            check("t5 hold product", 32'(bus.resp_product), 143);
            check("t5 hold id", 32'(bus.resp_id), 3);
            check("t5 hold valid", 32'(bus.resp_valid), 1);
            check("t5 hold req_ready", 32'(bus.req_ready), 0);
            check("t5 hold busy", 32'(bus.busy), 1);
        end
        take_resp("t5 r3");
        #1;
        check("t5 grant pending r1", 32'(bus.req_ready), 32'h2);
        step_clk();
        bus.req_valid[1] = 1'b0;
        wait_resp("t5 r1", 3, 49, 1);
        take_resp("t5 r1");

        // Reset during RUN aborts the operation and restores priority.
        set_req(2, 8'd200, 8'd100);
        #1;
        check("t6 grant r2", 32'(bus.req_ready), 32'h4);
        step_clk();
        bus.req_valid[2] = 1'b0;
        step_clk();
        step_clk();
        step_clk();
        check("t6 still running", 32'(bus.resp_valid), 0);
        set_req(1, 8'd3, 8'd5);
        set_req(3, 8'd2, 8'd2);
        rst_n = 1'b0;
        #1;
        check("t6 async valid", 32'(bus.resp_valid), 0);
        check("t6 async busy", 32'(bus.busy), 0);
        check("t6 async product", 32'(bus.resp_product), 0);
        check("t6 async id", 32'(bus.resp_id), 0);
        check("t6 async req_ready", 32'(bus.req_ready), 0);
        step_clk();
        step_clk();
        rst_n = 1'b1;
        #1;
        check("t6 post valid", 32'(bus.resp_valid), 0);
        check("t6 post busy", 32'(bus.busy), 0);
        check("t6 grant from r0", 32'(bus.req_ready), 32'h2);
        step_clk();
        bus.req_valid[1] = 1'b0;
        wait_resp("t6 r1", 3, 15, 1);
        take_resp("t6 r1");
        #1;
        check("t6 grant r3", 32'(bus.req_ready), 32'h8);
        step_clk();
        bus.req_valid[3] = 1'b0;
        wait_resp("t6 r3", 2, 4, 3);
        take_resp("t6 r3");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Shares one iterative Russian-peasant (shift-and-add) multiplier datapath between NUM_REQ requesters. Each requester gets a valid/ready request port, and arbitration is round-robin. The block latches the winner's operands and sequences the shift/add iterations, terminating early once the multiplier operand reaches zero. It returns the product and requester ID through a single valid/ready response port. It sits between the processing blocks that need occasional 8-bit products and the shared multiplier resource.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width; product is 2*WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*WIDTH  multiplicands, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  multipliers, same packing
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational, only in IDLE
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_product  out  2*WIDTH  a*b, exact (no overflow possible)
- resp_id  out  clog2(NUM_REQ)  index of requester the result belongs to
- busy  out  1  high in RUN and DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready is the one-hot winner among req_valid. Search starts at last_grant+1 and wraps modulo NUM_REQ.
  - If no request is valid, req_ready is 0.
  - Accept = req_valid[i] && req_ready[i].
- On an accept edge:
  - Latch a_reg=req_a[i], b_reg=req_b[i], acc=0, id=i, last_grant=i.
  - If req_b[i]==0, go to DONE; otherwise go to RUN.
- RUN, each edge:
  - If b_reg[0], acc += a_reg (2*WIDTH add).
  - a_reg <<= 1 (2*WIDTH wide), b_reg >>= 1.
  - If the shifted b_reg==0, go to DONE.
- DONE:
  - resp_valid=1; resp_product=acc and resp_id=id, held stable until resp_valid && resp_ready.
  - On that edge go to IDLE.
- No request is accepted outside IDLE; req_ready=0 in RUN and DONE.
- Requester inputs are sampled only at the accept edge. Later changes do not affect the in-flight operation.

## Timing
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority).
  - req_ready=0 while rst_n low.
  - resp_valid=0, resp_product=0, resp_id=0, busy=0.
- Latency: let k = index of the MSB set in b, plus 1 (k=0 for b==0, max WIDTH). resp_valid rises after accept edge + k edges.
  - b=7: k=3.
  - b=0: resp_valid high in the cycle after the accept edge.
- Throughput: one operation per k+2 cycles minimum, since DONE→IDLE costs one edge and IDLE→accept costs one edge.
- resp_ready held low: stay in DONE indefinitely with outputs stable. No request is lost; pending requests keep req_valid asserted and wait.
- Simultaneous requests: exactly one grant per accept. A requester that was just served has lowest priority at the next arbitration.
- Reset asserted mid-RUN or in DONE: the operation is aborted, no response is produced, and all outputs take reset values immediately (asynchronously).
- A req_valid drop in IDLE without accept is legal; the grant recomputes combinationally.

## Structure
- Package mult_sched_pkg: state enum (IDLE, RUN, DONE), default WIDTH/NUM_REQ constants, ID-width helper.
- Sub-module rp_mult_iter: holds a_reg/b_reg/acc and performs one shift/add step per cycle.
  - Inputs: load, a, b. Outputs: product, zero (b_reg==0 after step).
- Top level holds the FSM, the round-robin pointer and the response registers.

## Test plan
- Requester 0 sends a=6, b=7 alone → req_ready[0] in the same cycle; resp_valid 3 edges after accept with product=42, id=0.
- Requesters 0 and 2 assert together (15×5, 8×3) from reset → requester 0 served first (75, id 0), then requester 2 (24, id 2). Requester 2 re-requests while requester 1 is waiting → requester 1 served before requester 2.
- a=9, b=0 → product=0, resp_valid the cycle after accept, no RUN cycles.
- a=255, b=255 → product=65025 after 8 RUN edges. Also a=1, b=128 → 128 after 8 edges.
- resp_ready held low for 10 cycles in DONE → product and id stable, req_ready all 0, busy=1. Single accept when resp_ready rises, then IDLE.
- rst_n pulsed low during RUN of 200×100 → no resp_valid. After release, outputs are at reset values and the first new request is arbitrated from requester 0.
